// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the synchronous up/down counter.
//   DIR_UP / DIR_DN   : encoding of the mode input (count direction)
//   POL_WRAP / POL_SAT: encoding of the SATURATE parameter (range-end policy)
package counter_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int POL_WRAP = 0;
    localparam int POL_SAT  = 1;

endpackage

// File: rtl/sync_updown_counter_next.sv
// updown_next
//   Purely combinational next-state logic for sync_updown_counter.
//   Ports:
//     count     in  WIDTH  current registered count
//     mode      in  1      direction (DIR_UP / DIR_DN)
//     en        in  1      count enable
//     load      in  1      parallel load strobe (wins over en)
//     load_val  in  WIDTH  value to load
//     count_nxt out WIDTH  value for the count register
//     at_max    out 1      count == MODULUS-1
//     at_min    out 1      count == 0
//     wrap_ev   out 1      this edge wraps the count at a range end
//     ovf_ev    out 1      this edge attempts an up-step past MODULUS-1
//     unf_ev    out 1      this edge attempts a down-step below 0
//     load_oor  out 1      this edge loads an out-of-range value
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = POL_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_nxt,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_ev,
    output logic             ovf_ev,
    output logic             unf_ev,
    output logic             load_oor
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;

    // One extra bit keeps the increment from folding back to 0 when
    // MODULUS == 2**WIDTH, and turns the decrement borrow into a plain MSB test.
    assign count_ext = {1'b0, count};
    assign inc_ext   = count_ext + 1'b1;
    assign dec_ext   = count_ext - 1'b1;

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    always_comb begin
        count_nxt = count;
        wrap_ev   = 1'b0;
        ovf_ev    = 1'b0;
        unf_ev    = 1'b0;
        load_oor  = 1'b0;
        if (load) begin
            if (load_val > MAX_VAL) begin
                count_nxt = MAX_VAL;
                load_oor  = 1'b1;
            end else begin
                count_nxt = load_val;
            end
        end else if (en) begin
            if (mode == DIR_UP) begin
                if (inc_ext == MOD_EXT) begin
                    ovf_ev = 1'b1;
                    if (SATURATE == POL_WRAP) begin
                        count_nxt = '0;
                        wrap_ev   = 1'b1;
                    end
                end else begin
                    count_nxt = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (dec_ext[WIDTH]) begin
                    unf_ev = 1'b1;
                    if (SATURATE == POL_WRAP) begin
                        count_nxt = MAX_VAL;
                        wrap_ev   = 1'b1;
                    end
                end else begin
                    count_nxt = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   Synchronous up/down counter with programmable modulus, parallel load,
//   count enable and wrap/saturate policy. All bits update on the same edge.
//   Ports:
//     clk        in   1      clock, all state on posedge
//     reset      in   1      synchronous, active-high reset
//     en         in   1      count enable
//     mode       in   1      direction: 0 = up, 1 = down
//     load       in   1      parallel load strobe (priority over en)
//     load_val   in   WIDTH  value to load
//     clr_flags  in   1      clears sticky ovf/unf (a same-edge set wins)
//     count      out  WIDTH  registered count
//     tc         out  1      terminal count, combinational
//     wrap       out  1      registered pulse after a wrap edge
//     ovf        out  1      sticky up-overflow attempt
//     unf        out  1      sticky down-underflow attempt
//     load_err   out  1      registered pulse after an out-of-range load
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int SATURATE = POL_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             unf,
    output logic             load_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] count_nxt;
    logic             at_max, at_min;
    logic             wrap_ev, ovf_ev, unf_ev, load_oor;

    updown_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count     (count_q),
        .mode      (mode),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .count_nxt (count_nxt),
        .at_max    (at_max),
        .at_min    (at_min),
        .wrap_ev   (wrap_ev),
        .ovf_ev    (ovf_ev),
        .unf_ev    (unf_ev),
        .load_oor  (load_oor)
    );

    always_comb begin
        count_d    = count_nxt;
        wrap_d     = wrap_ev;
        load_err_d = load_oor;
        // Event is OR-ed in after the clear so a coincident set survives.
        ovf_d      = ovf_ev | (ovf_q & ~clr_flags);
        unf_d      = unf_ev | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign load_err = load_err_q;
    assign tc       = en & (((mode == DIR_UP) & at_max) | ((mode == DIR_DN) & at_min));

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench: three counter instances (M8 wrap, M6 wrap, M6 saturate)
// share one stimulus stream; each step names the instance it checks.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       en = 1'b0, mode = 1'b0, load = 1'b0, clr = 1'b0;
    logic [2:0] lv = 3'd0;

    logic [2:0] cnt0, cnt1, cnt2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2, ov0, ov1, ov2, un0, un1, un2, le0, le1, le2;

    sync_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_m8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(lv),
        .clr_flags(clr), .count(cnt0), .tc(tc0), .wrap(wr0), .ovf(ov0), .unf(un0),
        .load_err(le0));

    sync_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_m6 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(lv),
        .clr_flags(clr), .count(cnt1), .tc(tc1), .wrap(wr1), .ovf(ov1), .unf(un1),
        .load_err(le1));

    sync_updown_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_m6s (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(lv),
        .clr_flags(clr), .count(cnt2), .tc(tc2), .wrap(wr2), .ovf(ov2), .unf(un2),
        .load_err(le2));

    typedef struct {
        int         id;
        logic [7:0] vec;   // {count[2:0], tc, wrap, ovf, unf, load_err}
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic r, input logic e, input logic m, input logic l,
                        input logic [2:0] v, input logic c, input int id,
                        input logic [2:0] xc, input logic xt, input logic xw,
                        input logic xo, input logic xu, input logic xl, input string nm);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; mode = m; load = l; lv = v; clr = c;
        x.id  = id;
        x.vec = {xc, xt, xw, xo, xu, xl};
        x.nm  = nm;
        sb.push_back(x);
    endtask

    // Monitor: each stimulus step produces one DUT state update on the next
    // posedge; compare 2 time units after that edge.
    always @(posedge clk) begin
        exp_t       x;
        logic [7:0] act;
        #2;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.id)
                0:       act = {cnt0, tc0, wr0, ov0, un0, le0};
                1:       act = {cnt1, tc1, wr1, ov1, un1, le1};
                default: act = {cnt2, tc2, wr2, ov2, un2, le2};
            endcase
            checks++;
            if (act !== x.vec) begin
                errors++;
                $display("FAIL %s (dut%0d): got cnt=%0d tc=%b wrap=%b ovf=%b unf=%b lerr=%b, expected cnt=%0d tc=%b wrap=%b ovf=%b unf=%b lerr=%b",
                         x.nm, x.id, act[7:5], act[4], act[3], act[2], act[1], act[0],
                         x.vec[7:5], x.vec[4], x.vec[3], x.vec[2], x.vec[1], x.vec[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset, then count up with wrap (M8)
        step(1,0,0,0,3'd0,0, 0, 3'd0,0,0,0,0,0, "t1_rst_a");
        step(1,0,0,0,3'd0,0, 0, 3'd0,0,0,0,0,0, "t1_rst_b");
        for (int i = 1; i <= 7; i++)
            step(0,1,0,0,3'd0,0, 0, 3'(i), (i == 7),0,0,0,0, "t1_up");
        step(0,1,0,0,3'd0,0, 0, 3'd0,0,1,1,0,0, "t1_wrap");
        step(0,1,0,0,3'd0,0, 0, 3'd1,0,0,1,0,0, "t1_post1");
        step(0,1,0,0,3'd0,0, 0, 3'd2,0,0,1,0,0, "t1_post2");

        // 2: count down from reset (M6 wrap)
        step(1,0,0,0,3'd0,0, 1, 3'd0,0,0,0,0,0, "t2_rst");
        step(0,1,1,0,3'd0,0, 1, 3'd5,0,1,0,1,0, "t2_dn_wrap");
        for (int c = 4; c >= 0; c--)
            step(0,1,1,0,3'd0,0, 1, 3'(c), (c == 0),0,0,1,0, "t2_dn");
        step(0,1,1,0,3'd0,0, 1, 3'd5,0,1,0,1,0, "t2_dn_wrap2");

        // 3: saturate (M6 sat)
        step(1,0,0,0,3'd0,0, 2, 3'd0,0,0,0,0,0, "t3_rst");
        step(0,0,0,1,3'd4,0, 2, 3'd4,0,0,0,0,0, "t3_ld4");
        step(0,1,0,0,3'd0,0, 2, 3'd5,1,0,0,0,0, "t3_up5");
        step(0,1,0,0,3'd0,0, 2, 3'd5,1,0,1,0,0, "t3_sat_hi_a");
        step(0,1,0,0,3'd0,0, 2, 3'd5,1,0,1,0,0, "t3_sat_hi_b");
        step(0,1,1,1,3'd0,0, 2, 3'd0,1,0,1,0,0, "t3_ld0");
        step(0,1,1,0,3'd0,0, 2, 3'd0,1,0,1,1,0, "t3_sat_lo_a");
        step(0,1,1,0,3'd0,0, 2, 3'd0,1,0,1,1,0, "t3_sat_lo_b");

        // 4: load priority and range check (M6 wrap)
        step(1,0,0,0,3'd0,0, 1, 3'd0,0,0,0,0,0, "t4_rst");
        step(0,1,0,1,3'd3,0, 1, 3'd3,0,0,0,0,0, "t4_ld_pri");
        step(0,0,0,1,3'd7,0, 1, 3'd5,0,0,0,0,1, "t4_ld_oor7");
        step(0,0,0,0,3'd0,0, 1, 3'd5,0,0,0,0,0, "t4_lerr_once");
        step(0,0,0,1,3'd6,0, 1, 3'd5,0,0,0,0,1, "t4_ld_oor6");
        step(0,0,0,1,3'd5,0, 1, 3'd5,0,0,0,0,0, "t4_ld_max");
        step(0,0,0,1,3'd0,0, 1, 3'd0,0,0,0,0,0, "t4_ld_min");

        // 5: flags and direction change (M8)
        step(1,0,0,0,3'd0,0, 0, 3'd0,0,0,0,0,0, "t5_rst");
        step(0,0,0,1,3'd7,0, 0, 3'd7,0,0,0,0,0, "t5_ld7");
        step(0,1,0,0,3'd0,1, 0, 3'd0,0,1,1,0,0, "t5_set_wins");
        step(0,0,0,0,3'd0,1, 0, 3'd0,0,0,0,0,0, "t5_clr");
        step(0,0,0,1,3'd3,0, 0, 3'd3,0,0,0,0,0, "t5_ld3");
        step(0,1,0,0,3'd0,0, 0, 3'd4,0,0,0,0,0, "t5_up4");
        step(0,1,1,0,3'd0,0, 0, 3'd3,0,0,0,0,0, "t5_flip");
        step(0,1,1,0,3'd0,0, 0, 3'd2,0,0,0,0,0, "t5_dn2");

        // 6: reset during load, then enable hold (M8)
        step(0,0,0,1,3'd7,0, 0, 3'd7,0,0,0,0,0, "t6_ld7");
        step(0,1,0,0,3'd0,0, 0, 3'd0,0,1,1,0,0, "t6_wrap");
        step(0,0,0,1,3'd6,0, 0, 3'd6,0,0,1,0,0, "t6_ld6");
        step(1,1,0,1,3'd2,0, 0, 3'd0,0,0,0,0,0, "t6_rst_ld");
        step(0,1,0,0,3'd0,0, 0, 3'd1,0,0,0,0,0, "t6_resume");
        for (int k = 0; k < 3; k++)
            step(0,0,0,0,3'd0,0, 0, 3'd1,0,0,0,0,0, "t6_hold");

        @(negedge clk);
        en = 1'b0; load = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
